// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
//   - op encodings carried on i_op
//   - FSM state encodings
//   - iteration count and a signed/unsigned magnitude helper
package muldiv_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int         ITER_COUNT = 32;
    localparam logic [4:0] LAST_ITER  = 5'(ITER_COUNT - 1);

    // Magnitude of a 32-bit operand. 0x80000000 maps to itself, which is
    // exactly what the signed-overflow divide case relies on.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   i_acc    : 64-bit accumulator. Multiply: {partial product, multiplier}.
//              Divide: {partial remainder, remaining dividend / quotient}.
//   i_opnd   : multiplicand (multiply) or divisor (divide), magnitudes
//   i_is_div : 1 = restoring divide step, 0 = shift-add multiply step
//   o_acc    : next accumulator; for divide the LSB is left 0 and the
//              caller merges o_qbit into it
//   o_qbit   : quotient bit produced by this divide step (0 for multiply)
import muldiv_unit_pkg::*;

module muldiv_step (
    input  logic [63:0] i_acc,
    input  logic [31:0] i_opnd,
    input  logic        i_is_div,
    output logic [63:0] o_acc,
    output logic        o_qbit
);

    logic [32:0] w_sum;
    logic [32:0] w_shl;
    logic [32:0] w_diff;
    logic        w_q;

    always_comb begin
        w_sum  = {1'b0, i_acc[63:32]} + {1'b0, i_opnd};
        // Partial remainder shifted left with the next dividend bit.
        w_shl  = i_acc[63:31];
        // Remainder stays below the divisor, so bit 32 of the 33-bit
        // difference is a reliable borrow.
        w_diff = w_shl - {1'b0, i_opnd};
        w_q    = 1'b0;
        o_acc  = '0;
        if (i_is_div) begin
            w_q   = ~w_diff[32];
            o_acc = {(w_q ? w_diff[31:0] : w_shl[31:0]), i_acc[30:0], 1'b0};
        end else begin
            // Add multiplicand into the top half when the multiplier LSB is
            // set, then shift the whole accumulator right with the carry.
            o_acc = i_acc[0] ? {w_sum, i_acc[31:1]} : {1'b0, i_acc[63:1]};
        end
        o_qbit = w_q;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
//   clk, rst_n      : clock (rising edge), async active-low reset
//   i_start, i_op   : request valid and opcode (sampled only in IDLE)
//   i_src_a/i_src_b : rs / rt operands
//   i_wr_hi/i_wr_lo : MTHI/MTLO strobes with i_wr_data (IDLE only)
//   i_flush         : abort to IDLE at the next edge, HI/LO untouched
//   o_busy, o_done  : state != IDLE, one-cycle completion pulse
//   o_hi, o_lo      : HI/LO registers
// Accept -> 32 CALC cycles -> FIX (negate + commit) -> DONE -> IDLE.
import muldiv_unit_pkg::*;

module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic        i_wr_hi,
    input  logic        i_wr_lo,
    input  logic [31:0] i_wr_data,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_is_div;
    logic        r_neg_lo;   // product sign (multiply) or quotient sign
    logic        r_neg_hi;   // remainder sign
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_div;
    logic        w_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [63:0] w_step_acc;
    logic        w_qbit;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_is_div = i_op[1];
    assign w_signed = ~i_op[0];
    assign w_a_abs  = abs32(i_src_a, w_signed);
    assign w_b_abs  = abs32(i_src_b, w_signed);

    muldiv_step u_step (
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .i_is_div (r_is_div),
        .o_acc    (w_step_acc),
        .o_qbit   (w_qbit)
    );

    assign w_prod   = r_neg_lo ? (64'd0 - r_acc) : r_acc;
    assign w_quo    = r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem    = r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_res_hi = r_is_div ? w_rem : w_prod[63:32];
    assign w_res_lo = r_is_div ? w_quo : w_prod[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            // MTHI/MTLO land in IDLE even alongside an accepted start; the
            // eventual result then overwrites them.
            if (r_state == S_IDLE) begin
                if (i_wr_hi) r_hi <= i_wr_data;
                if (i_wr_lo) r_lo <= i_wr_data;
            end
            if (i_flush) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_is_div <= w_is_div;
                            r_neg_lo <= w_signed & (i_src_a[31] ^ i_src_b[31]);
                            r_neg_hi <= w_signed & i_src_a[31];
                            // Multiply: multiplier in the low half, shifted out.
                            // Divide: dividend in the low half, shifted into
                            // the remainder as quotient bits fill in.
                            r_acc    <= {32'd0, (w_is_div ? w_a_abs : w_b_abs)};
                            r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                            r_cnt    <= '0;
                            r_state  <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_step_acc | {63'd0, w_qbit};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == LAST_ITER) r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= S_DONE;
                    end
                    default: r_state <= S_IDLE;   // S_DONE
                endcase
            end
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
